// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register pending-write counter used for RAW hazard detection.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write-back data and post-write busy to the read ports.
module regfile_scoreboard #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NREAD = 2,
    parameter  int CNTW  = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    output logic                  iss_ready,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  err_underflow
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [CNTW-1:0] cnt_q  [NREGS];
    logic [CNTW-1:0] cnt_d  [NREGS];
    logic            err_q;
    logic            err_d;

    logic            wb_act_s;
    logic            iss_acc_s;
    logic [AW-1:0]   rd_a_s    [NREAD];
    logic [XLEN-1:0] rd_val_s  [NREAD];
    logic            rd_bsy_s  [NREAD];

    // Issue handshake: a full counter can still accept when a write-back to it retires this cycle.
    always_comb begin
        wb_act_s  = wb_en && (wb_addr != AW'(0));
        iss_ready = (iss_rd == AW'(0))
                 || (cnt_q[iss_rd] != CNT_MAX)
                 || (wb_act_s && (wb_addr == iss_rd) && (cnt_q[iss_rd] != CNTW'(0)));
        iss_acc_s = iss_valid && iss_ready && (iss_rd != AW'(0));
    end

    // Next state: write-back applied first, then the issue increment stacks on top of it.
    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (wb_act_s) begin
            regs_d[wb_addr] = wb_data;
            if (cnt_q[wb_addr] == CNTW'(0)) begin
                err_d = 1'b1;
            end else begin
                cnt_d[wb_addr] = cnt_q[wb_addr] - CNTW'(1);
            end
        end else begin
            err_d = err_q;
        end
        if (iss_acc_s) begin
            cnt_d[iss_rd] = cnt_d[iss_rd] + CNTW'(1);
        end else begin
            cnt_d[iss_rd] = cnt_d[iss_rd];
        end
    end

    // State registers; register 0 is never written so it stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Combinational read ports with register 0 forced to zero and never busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            rd_a_s[i]   = rd_addr[i*AW +: AW];
            rd_val_s[i] = regs_q[rd_a_s[i]];
            rd_bsy_s[i] = (cnt_q[rd_a_s[i]] != CNTW'(0));
`ifdef REGFILE_BYPASS_EN
            if (wb_act_s && (rd_a_s[i] == wb_addr)) begin
                rd_val_s[i] = wb_data;
                rd_bsy_s[i] = (cnt_q[rd_a_s[i]] > CNTW'(1));
            end else begin
                rd_val_s[i] = regs_q[rd_a_s[i]];
            end
`endif
            if (rd_a_s[i] == AW'(0)) begin
                rd_val_s[i] = '0;
                rd_bsy_s[i] = 1'b0;
            end else begin
                rd_bsy_s[i] = rd_bsy_s[i];
            end
            rd_data[i*XLEN +: XLEN] = rd_val_s[i];
            rd_busy[i]              = rd_bsy_s[i];
        end
    end

    assign err_underflow = err_q;

endmodule
